// File: rtl/prince_sbox_cms_pkg.sv
// Shared types and the fixed quadratic map of the masked PRINCE S-box stage.
package prince_sbox_cms_pkg;

  // Share nibble ordering: bit 0 = x, 1 = w, 2 = v, 3 = u
  typedef logic [0:3] share_t;

  localparam logic [1:0] VAR_X = 2'd0;
  localparam logic [1:0] VAR_W = 2'd1;
  localparam logic [1:0] VAR_V = 2'd2;
  localparam logic [1:0] VAR_U = 2'd3;

  // ANF of Q per output bit k: y[k] = s[LIN_IDX[k]] ^ s[A_IDX[k]] & s[B_IDX[k]]
  localparam logic [1:0] LIN_IDX [0:3] = '{VAR_U, VAR_V, VAR_W, VAR_X};
  localparam logic [1:0] A_IDX   [0:3] = '{VAR_X, VAR_X, VAR_V, VAR_W};
  localparam logic [1:0] B_IDX   [0:3] = '{VAR_W, VAR_U, VAR_U, VAR_V};

  // Unmasked reference of Q
  function automatic share_t q_ref(input share_t s);
    share_t y;
    for (int k = 0; k < 4; k++) begin
      y[k] = s[LIN_IDX[k]] ^ (s[A_IDX[k]] & s[B_IDX[k]]);
    end
    return y;
  endfunction

endpackage

// File: rtl/prince_sbox_cms_quad_stage_cms_and_terms.sv
// Four refreshed cross-domain terms for one masked output bit.
// The random bit enters both share-0 terms so it cancels only after compression.
module cms_and_terms (
  input  logic i_l0,
  input  logic i_l1,
  input  logic i_a0,
  input  logic i_a1,
  input  logic i_b0,
  input  logic i_b1,
  input  logic i_r,
  output logic o_t00,
  output logic o_t01,
  output logic o_t10,
  output logic o_t11
);

  assign o_t00 = i_l0 ^ (i_a0 & i_b0) ^ i_r;
  assign o_t01 = (i_a0 & i_b1) ^ i_r;
  assign o_t10 = i_l1 ^ (i_a1 & i_b0);
  assign o_t11 = i_a1 & i_b1;

endmodule

// File: rtl/prince_sbox_cms_quad_stage.sv
// Registered quadratic stage of the 2-share CMS PRINCE S-box with an elastic
// valid/ready pipeline: term register T, then optional output register.
module prince_sbox_cms_quad_stage
  import prince_sbox_cms_pkg::*;
#(
  parameter int OUT_REG     = 1,
  parameter int STALL_CNT_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [0:3]             i_in0,
  input  logic [0:3]             i_in1,
  input  logic [0:3]             i_rnd,
  input  logic                   i_rnd_valid,
  output logic                   o_rnd_ack,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [0:3]             o_out0,
  output logic [0:3]             o_out1,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  share_t w_t00, w_t01, w_t10, w_t11;
  share_t r_t00, r_t01, r_t10, r_t11;
  share_t w_c0, w_c1;
  logic   r_t_vld;
  logic   w_t_adv;
  logic   w_ready;
  logic   w_fire;
  logic   w_starve;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  for (genvar k = 0; k < 4; k++) begin : g_bit
    cms_and_terms u_terms (
      .i_l0  (i_in0[LIN_IDX[k]]),
      .i_l1  (i_in1[LIN_IDX[k]]),
      .i_a0  (i_in0[A_IDX[k]]),
      .i_a1  (i_in1[A_IDX[k]]),
      .i_b0  (i_in0[B_IDX[k]]),
      .i_b1  (i_in1[B_IDX[k]]),
      .i_r   (i_rnd[k]),
      .o_t00 (w_t00[k]),
      .o_t01 (w_t01[k]),
      .o_t10 (w_t10[k]),
      .o_t11 (w_t11[k])
    );
  end

  // Compression stays within one share index; share domains never mix here
  assign w_c0 = r_t00 ^ r_t01;
  assign w_c1 = r_t10 ^ r_t11;

  // Reset holds o_ready low so nothing is accepted or acknowledged during it
  assign w_ready   = i_rst_n & (~r_t_vld | w_t_adv);
  assign w_fire    = i_valid & w_ready & i_rnd_valid;
  assign w_starve  = i_valid & w_ready & ~i_rnd_valid;
  assign o_ready   = w_ready;
  assign o_rnd_ack = w_fire;

  // Term register: load on fire, empty when its content moves downstream
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_t_vld <= 1'b0;
      r_t00   <= '0;
      r_t01   <= '0;
      r_t10   <= '0;
      r_t11   <= '0;
    end else if (w_fire) begin
      r_t_vld <= 1'b1;
      r_t00   <= w_t00;
      r_t01   <= w_t01;
      r_t10   <= w_t10;
      r_t11   <= w_t11;
    end else if (w_t_adv) begin
      r_t_vld <= 1'b0;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic   r_o_vld;
    share_t r_out0, r_out1;

    assign w_t_adv = r_t_vld & (~r_o_vld | i_ready);

    // Output register: take T when it advances, otherwise drain on i_ready
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_o_vld <= 1'b0;
        r_out0  <= '0;
        r_out1  <= '0;
      end else if (w_t_adv) begin
        r_o_vld <= 1'b1;
        r_out0  <= w_c0;
        r_out1  <= w_c1;
      end else if (i_ready) begin
        r_o_vld <= 1'b0;
      end
    end

    assign o_valid = r_o_vld;
    assign o_out0  = r_out0;
    assign o_out1  = r_out1;
  end else begin : g_out_comb
    assign w_t_adv = r_t_vld & i_ready;
    assign o_valid = r_t_vld;
    assign o_out0  = w_c0;
    assign o_out1  = w_c1;
  end

  // Saturating count of accept opportunities lost to missing randomness
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_starve && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_prince_sbox_cms_quad_stage.sv
// Directed bench: instance A (OUT_REG=1, 8-bit counter), instance B (OUT_REG=0, 2-bit counter).
module tb_prince_sbox_cms_quad_stage;

  logic       clk;
  logic       rst_n;

  logic       a_valid, a_ready_o, a_rnd_valid, a_ack, a_ovalid, a_ready;
  logic [0:3] a_in0, a_in1, a_rnd, a_out0, a_out1;
  logic [7:0] a_stall;

  logic       b_valid, b_ready_o, b_rnd_valid, b_ack, b_ovalid, b_ready;
  logic [0:3] b_in0, b_in1, b_rnd, b_out0, b_out1;
  logic [1:0] b_stall;

  int n_tests = 0;
  int n_fail  = 0;

  prince_sbox_cms_quad_stage #(.OUT_REG(1), .STALL_CNT_W(8)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .o_ready(a_ready_o),
    .i_in0(a_in0), .i_in1(a_in1), .i_rnd(a_rnd), .i_rnd_valid(a_rnd_valid),
    .o_rnd_ack(a_ack), .o_valid(a_ovalid), .i_ready(a_ready),
    .o_out0(a_out0), .o_out1(a_out1), .o_stall_cnt(a_stall)
  );

  prince_sbox_cms_quad_stage #(.OUT_REG(0), .STALL_CNT_W(2)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .o_ready(b_ready_o),
    .i_in0(b_in0), .i_in1(b_in1), .i_rnd(b_rnd), .i_rnd_valid(b_rnd_valid),
    .o_rnd_ack(b_ack), .o_valid(b_ovalid), .i_ready(b_ready),
    .o_out0(b_out0), .o_out1(b_out1), .o_stall_cnt(b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected compressed shares {out0,out1}; randomness cancels after compression
  function automatic logic [7:0] model(input logic [0:3] a, input logic [0:3] b);
    logic x, w, v, u;
    logic [0:3] o0, o1;
    x = a[0] ^ b[0]; w = a[1] ^ b[1]; v = a[2] ^ b[2]; u = a[3] ^ b[3];
    o0[0] = a[3] ^ (a[0] & w);  o1[0] = b[3] ^ (b[0] & w);
    o0[1] = a[2] ^ (a[0] & u);  o1[1] = b[2] ^ (b[0] & u);
    o0[2] = a[1] ^ (a[2] & u);  o1[2] = b[1] ^ (b[2] & u);
    o0[3] = a[0] ^ (a[1] & v);  o1[3] = b[0] ^ (b[1] & v);
    if (x === 1'bx) o0 = 'x;
    return {o0, o1};
  endfunction

  initial begin
    logic [7:0] iv;
    logic [7:0] e;
    rst_n = 1'b0;
    a_valid = 1'b1; a_rnd_valid = 1'b1; a_ready = 1'b1;
    a_in0 = 4'b1011; a_in1 = 4'b0110; a_rnd = 4'b0101;
    b_valid = 1'b0; b_rnd_valid = 1'b0; b_ready = 1'b1;
    b_in0 = '0; b_in1 = '0; b_rnd = '0;

    // reset state
    tick(); tick();
    chk("rst_ready", a_ready_o, 0);
    chk("rst_ack", a_ack, 0);
    chk("rst_valid", a_ovalid, 0);
    chk("rst_out", {a_out0, a_out1}, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_b_out", {b_ovalid, b_out0, b_out1, b_stall}, 0);
    a_valid = 1'b0; a_rnd_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", a_ready_o, 1);

    // randomness without input is ignored
    a_rnd_valid = 1'b1;
    #1 chk("rnd_only_ack", a_ack, 0);
    tick();
    chk("rnd_only_state", {a_ovalid, a_stall}, 0);

    // single item, latency 2
    a_in0 = 4'b1011; a_in1 = 4'b0110; a_rnd = 4'b0101; a_valid = 1'b1;
    #1 chk("t1_ack", a_ack, 1);
    tick();
    a_valid = 1'b0;
    chk("t1_lat1_valid", a_ovalid, 0);
    tick();
    chk("t1_out", {a_ovalid, a_out0, a_out1}, {1'b1, 4'b0011, 4'b0100});
    tick();
    chk("t1_drain", a_ovalid, 0);

    // exhaustive back-to-back stream
    for (int i = 0; i <= 256; i++) begin
      if (i < 256) begin
        iv = 8'(i);
        a_in0 = iv[7:4]; a_in1 = iv[3:0]; a_rnd = 4'($urandom_range(0, 15));
        a_valid = 1'b1;
        #1 chk("exh_ready", a_ready_o, 1);
      end else begin
        a_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        iv = 8'(i - 1);
        e = model(iv[7:4], iv[3:0]);
        chk($sformatf("exh_%0d", i - 1), {a_ovalid, a_out0, a_out1}, {1'b1, e});
      end
    end
    tick();
    chk("exh_empty", a_ovalid, 0);

    // randomness starvation
    a_in0 = 4'b1100; a_in1 = 4'b0101; a_rnd = 4'b1001;
    a_valid = 1'b1; a_rnd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("starve_ack", {a_ready_o, a_ack}, 2'b10);
      tick();
    end
    chk("starve_cnt", {a_ovalid, a_stall}, {1'b0, 8'd5});
    a_rnd_valid = 1'b1;
    #1 chk("starve_fire_ack", a_ack, 1);
    tick();
    a_valid = 1'b0;
    chk("starve_cnt_hold", a_stall, 5);
    tick();
    chk("starve_out", {a_ovalid, a_out0, a_out1}, {1'b1, model(4'b1100, 4'b0101)});
    tick();
    chk("starve_single", a_ovalid, 0);

    // backpressure with full pipeline
    a_ready = 1'b0;
    a_in0 = 4'b0011; a_in1 = 4'b1110; a_valid = 1'b1;
    tick();
    a_in0 = 4'b1111; a_in1 = 4'b0000;
    tick();
    a_in0 = 4'b0101; a_in1 = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", {a_ready_o, a_ack}, 0);
      chk("bp_hold", {a_ovalid, a_out0, a_out1}, {1'b1, model(4'b0011, 4'b1110)});
      tick();
    end
    a_ready = 1'b1;
    #1 chk("bp_release", {a_ready_o, a_ack}, 2'b11);
    tick();
    a_valid = 1'b0;
    chk("bp_item1", {a_ovalid, a_out0, a_out1}, {1'b1, model(4'b1111, 4'b0000)});
    tick();
    chk("bp_item2", {a_ovalid, a_out0, a_out1}, {1'b1, model(4'b0101, 4'b1001)});
    tick();
    chk("bp_empty", a_ovalid, 0);

    // reset with two items in flight
    a_in0 = 4'b1000; a_in1 = 4'b0001; a_valid = 1'b1;
    tick();
    a_in0 = 4'b0111; a_in1 = 4'b0100;
    tick();
    a_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst", {a_ready_o, a_ovalid, a_out0, a_out1, a_stall}, 0);
    rst_n = 1'b1;
    tick();
    chk("mid_rst_after1", {a_ready_o, a_ovalid}, 2'b10);
    tick();
    chk("mid_rst_after2", a_ovalid, 0);

    // OUT_REG=0 instance: latency 1
    b_in0 = 4'b1011; b_in1 = 4'b0110; b_rnd = 4'b1010;
    b_valid = 1'b1; b_rnd_valid = 1'b1; b_ready = 1'b1;
    #1 chk("b_ack", {b_ready_o, b_ack}, 2'b11);
    tick();
    b_valid = 1'b0;
    chk("b_out", {b_ovalid, b_out0, b_out1}, {1'b1, 4'b0011, 4'b0100});
    tick();
    chk("b_drain", b_ovalid, 0);

    // OUT_REG=0 backpressure blocks the single slot
    b_ready = 1'b0; b_valid = 1'b1;
    tick();
    chk("b_bp_ready", {b_ready_o, b_ack, b_ovalid}, 3'b001);
    b_valid = 1'b0; b_ready = 1'b1;
    tick();
    chk("b_bp_drain", b_ovalid, 0);

    // 2-bit stall counter saturates at 3
    b_valid = 1'b1; b_rnd_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("b_sat_%0d", i), b_stall, (i < 3) ? i : 3);
    end
    b_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
